mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 99 +++++++++
 tb/tb_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: 2^DEPTH_LOG2 x 128-bit backing store with byte-masked writes and
// fixed-latency, fully pipelined reads. Define MEM_RESP_STALL_EN for LFSR-driven request stalls.
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_req_valid,
  output logic         mem_req_ready,
  input  logic [27:0]  mem_req_addr,
  input  logic         mem_req_rw,
  input  logic         mem_req_data_valid,
  output logic         mem_req_data_ready,
  input  logic [127:0] mem_req_data_bits,
  input  logic [15:0]  mem_req_data_mask,
  output logic         mem_resp_valid,
  output logic [127:0] mem_resp_data
);

  // Handshake: a command transfers on a rising edge where mem_req_valid and
  // mem_req_ready are both high; a write also needs mem_req_data_valid in that
  // same cycle or it does not transfer at all. mem_req_data_ready mirrors
  // mem_req_ready. Responses have no ready: mem_resp_valid is a single-cycle
  // pulse per accepted read, in accept order.

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  ready;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_addr_hi;

  logic [127:0]          store [DEPTH];
  logic [LATENCY-1:0]    pipe_valid;
  logic [127:0]          pipe_data [LATENCY];

`ifdef MEM_RESP_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; stall whenever the low two bits are zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign ready = (lfsr[1:0] != 2'b00);
`else
  assign ready = 1'b1;
`endif

  assign mem_req_ready      = ready;
  assign mem_req_data_ready = ready;

  // Upper address bits alias onto the store.
  assign idx            = mem_req_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^mem_req_addr[27:DEPTH_LOG2];

  assign wr_accept = mem_req_valid & mem_req_rw & mem_req_data_valid & ready;
  assign rd_accept = mem_req_valid & ~mem_req_rw & ready;

  // Store is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int b = 0; b < 16; b++) begin
        if (mem_req_data_mask[b]) begin
          store[idx][8*b +: 8] <= mem_req_data_bits[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 samples the store at the accept edge, so a write accepted one edge
  // earlier is already visible. Idle stages carry zero data so the output needs
  // no masking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_accept;
      pipe_data[0]  <= rd_accept ? store[idx] : 128'd0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign mem_resp_valid = pipe_valid[LATENCY-1];
  assign mem_resp_data  = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a store/latency model with a per-cycle compare process
// plus directed scenarios pinned by literal expectations.
module tb_mem_responder;

  localparam int DL    = 10;
  localparam int LAT   = 4;
  localparam int DEPTH = 1 << DL;
  localparam logic [127:0] MASKED_LIT = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mem_req_valid = 1'b0;
  logic         mem_req_ready;
  logic [27:0]  mem_req_addr = '0;
  logic         mem_req_rw = 1'b0;
  logic         mem_req_data_valid = 1'b0;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits = '0;
  logic [15:0]  mem_req_data_mask = '0;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_req_rw         (mem_req_rw),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int           cyc = 0;
  logic [127:0] model_mem [DEPTH];
  logic [127:0] exp_q[$];
  int           due_q[$];
  logic [7:0]   m_lfsr = 8'hA5;
  logic         m_ready = 1'b1;
  logic         m_edge_ready = 1'b0;
  int           m_last_acc_cyc = 0;
  int           acc_cnt = 0;

  always @(posedge clk) begin
    logic [127:0] tmp;
    cyc++;
    m_edge_ready = m_ready;
    if (!reset) begin
      exp_q.delete();
      due_q.delete();
      m_lfsr = 8'hA5;
    end else begin
      if (mem_req_valid && m_ready) begin
        if (mem_req_rw) begin
          if (mem_req_data_valid) begin
            tmp = model_mem[mem_req_addr[DL-1:0]];
            for (int b = 0; b < 16; b++)
              if (mem_req_data_mask[b]) tmp[8*b +: 8] = mem_req_data_bits[8*b +: 8];
            model_mem[mem_req_addr[DL-1:0]] = tmp;
          end
        end else begin
          exp_q.push_back(model_mem[mem_req_addr[DL-1:0]]);
          due_q.push_back(cyc + LAT - 1);
          m_last_acc_cyc = cyc;
          acc_cnt++;
        end
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
`ifdef MEM_RESP_STALL_EN
    m_ready = (m_lfsr[1:0] != 2'b00);
`else
    m_ready = 1'b1;
`endif
  end

  // ---------------- scoreboard / compare ----------------
  logic [127:0] resp_log[$];
  int           resp_cyc_log[$];
  int           dut_rdy_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_resp_valid", mem_resp_valid, 128'd0);
      check("rst_resp_data", mem_resp_data, 128'd0);
      check("rst_req_ready", mem_req_ready, 128'd1);
    end else begin
      check("req_ready", mem_req_ready, m_ready);
      check("req_data_ready", mem_req_data_ready, m_ready);
      if (mem_req_valid && mem_req_ready) dut_rdy_cnt++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        check("resp_valid", mem_resp_valid, 128'd1);
        check("resp_data", mem_resp_data, exp_q[0]);
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end else begin
        check("resp_valid_idle", mem_resp_valid, 128'd0);
        check("resp_data_idle", mem_resp_data, 128'd0);
      end
      if (mem_resp_valid) begin
        resp_log.push_back(mem_resp_data);
        resp_cyc_log.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic rw, input logic [27:0] addr, input logic [127:0] data,
                       input logic [15:0] mask, input logic dv);
    int n = 0;
    mem_req_valid      = 1'b1;
    mem_req_rw         = rw;
    mem_req_addr       = addr;
    mem_req_data_bits  = data;
    mem_req_data_mask  = mask;
    mem_req_data_valid = dv;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!m_edge_ready && n < 64);
    check("issue_accept", m_edge_ready, 128'd1);
  endtask

  task automatic drain();
    int n = 0;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    while ((due_q.size() > 0 || n < 2) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", due_q.size(), 128'd0);
  endtask

  function automatic void clear_logs();
    resp_log.delete();
    resp_cyc_log.delete();
  endfunction

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int start_acc;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Full write then low-nibble byte clear.
    issue(1'b1, 28'd5, {128{1'b1}}, 16'hFFFF, 1'b1);
    issue(1'b1, 28'd5, 128'd0, 16'h000F, 1'b1);
    clear_logs();
    issue(1'b0, 28'd5, 128'd0, 16'h0, 1'b0);
    drain();
    check("pin_mask_model", model_mem[5], MASKED_LIT);
    check("mask_resp_count", resp_log.size(), 128'd1);
    if (resp_log.size() == 1) begin
      check("mask_resp_data", resp_log[0], MASKED_LIT);
      check("mask_latency", resp_cyc_log[0] - m_last_acc_cyc, LAT - 1);
    end

    // Back-to-back reads of 8..11 holding 1..4.
    for (int i = 0; i < 4; i++) issue(1'b1, 28'(8 + i), 128'(i + 1), 16'hFFFF, 1'b1);
    clear_logs();
    for (int i = 0; i < 4; i++) issue(1'b0, 28'(8 + i), 128'd0, 16'h0, 1'b0);
    drain();
    check("b2b_count", resp_log.size(), 128'd4);
    for (int i = 0; i < resp_log.size(); i++) begin
      check("b2b_data", resp_log[i], 128'(i + 1));
`ifndef MEM_RESP_STALL_EN
      if (i > 0) check("b2b_consecutive", resp_cyc_log[i] - resp_cyc_log[i-1], 128'd1);
`endif
    end

    // Write-then-read forwarding and address aliasing.
    clear_logs();
    issue(1'b1, 28'd3, 128'd7, 16'hFFFF, 1'b1);
    issue(1'b0, 28'd3, 128'd0, 16'h0, 1'b0);
    issue(1'b0, 28'(3 + DEPTH), 128'd0, 16'h0, 1'b0);
    issue(1'b1, 28'(4 + 2 * DEPTH), 128'h1234, 16'hFFFF, 1'b1);
    issue(1'b0, 28'd4, 128'd0, 16'h0, 1'b0);
    drain();
    check("pin_alias_model", model_mem[4], 128'h1234);
    check("alias_count", resp_log.size(), 128'd3);
    if (resp_log.size() == 3) begin
      check("fwd_data", resp_log[0], 128'd7);
      check("alias_rd_data", resp_log[1], 128'd7);
      check("alias_wr_data", resp_log[2], 128'h1234);
    end

    // Write without data valid, and stray data valid, both ignored.
    issue(1'b1, 28'd2, 128'd9, 16'hFFFF, 1'b1);
    issue(1'b1, 28'd2, 128'h55, 16'hFFFF, 1'b0);
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b1;
    mem_req_data_valid = 1'b1;
    mem_req_data_bits  = 128'hAA;
    @(posedge clk); #1;
    clear_logs();
    issue(1'b0, 28'd2, 128'd0, 16'h0, 1'b0);
    drain();
    check("pin_nodv_model", model_mem[2], 128'd9);
    check("nodv_count", resp_log.size(), 128'd1);
    if (resp_log.size() == 1) check("nodv_data", resp_log[0], 128'd9);

    // Reset pulse discards in-flight reads; store survives.
    for (int i = 0; i < 3; i++) issue(1'b1, 28'(20 + i), 128'(100 + i), 16'hFFFF, 1'b1);
    for (int i = 0; i < 3; i++) issue(1'b0, 28'(20 + i), 128'd0, 16'h0, 1'b0);
    mem_req_valid = 1'b0;
    reset = 1'b0;
    clear_logs();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_resp", resp_log.size(), 128'd0);
    issue(1'b0, 28'd21, 128'd0, 16'h0, 1'b0);
    drain();
    check("post_rst_count", resp_log.size(), 128'd1);
    if (resp_log.size() == 1) check("post_rst_data", resp_log[0], 128'd101);

    // Sustained read burst; accepts must match ready-high cycles.
    clear_logs();
    dut_rdy_cnt = 0;
    start_acc   = acc_cnt;
    for (int i = 0; i < 64; i++) issue(1'b0, 28'(8 + (i % 4)), 128'd0, 16'h0, 1'b0);
    drain();
    check("burst_accepts", acc_cnt - start_acc, 128'd64);
    check("burst_ready_cycles", dut_rdy_cnt, 128'd64);
    check("burst_count", resp_log.size(), 128'd64);
    for (int i = 0; i < resp_log.size(); i++) check("burst_order", resp_log[i], 128'((i % 4) + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
